uart_block_assembler: RTL and testbench

Receive-side framer for the UART link: collects the byte stream from the UART receiver (8-bit data plus one-cycle valid strobe) into 128-bit blocks, MSB-first, and presents each completed block on a valid/ready handshake.
- Sits between the UART receiver and any 128-bit consumer, such as the AES/hybrid data path or a loopback/encrypt path.
- Mirrors the 16-byte MSB-first serializer on the transmit side.
- Discards partial blocks after an inter-byte gap timeout so the link self-resynchronizes.

---
 rtl/uart_block_pkg.sv | 13 +
 rtl/uart_gap_timer.sv | 33 +++
 rtl/uart_block_assembler.sv | 102 ++++++++++
 tb/tb_uart_block_assembler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_block_pkg.sv
// Shared definitions for the UART block framing path (assembler and serializer).
package uart_block_pkg;

  typedef enum logic [1:0] {
    ASM_IDLE,
    ASM_COLLECT,
    ASM_HOLD
  } asm_state_t;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BLOCK_BITS  = 128;

endpackage : uart_block_pkg

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and flags the
// terminal-count cycle so a stalled partial block can be discarded.
module uart_gap_timer #(
  parameter int unsigned GAP_CYCLES = 34720
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count idle cycles; a byte or a disabled timer restarts from zero, and the
  // count saturates at terminal so it never wraps into a false second expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (cnt != TERM) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A byte arriving on the terminal cycle wins over the expiry.
  assign expired = enable && !clear && (cnt == TERM);

endmodule : uart_gap_timer

// File: rtl/uart_block_assembler.sv
// Receive-side framer: packs UART bytes MSB-first into 128-bit blocks, holds
// each finished block on a valid/ready handshake, and drops stalled partial
// blocks after an inter-byte gap timeout.
module uart_block_assembler
  import uart_block_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned GAP_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [BLOCK_BITS-1:0] block_data,
  output logic                  block_valid,
  input  logic                  block_ready,
  output logic                  timeout_err,
  output logic                  overrun_err,
  output logic [4:0]            byte_count
);

  // Idle byte-times are 10 bit periods (start + 8 data + stop).
  localparam int unsigned GAP_CYCLES = (CLK_FREQ / BAUD_RATE) * 10 * GAP_BYTES;
  localparam logic [4:0]  LAST_COUNT = 5'(BLOCK_BYTES - 1);

  asm_state_t state;
  logic       gap_enable;
  logic       gap_expired;

  // The gap timer only runs while a partial block is being collected.
  assign gap_enable = (state == ASM_COLLECT);

  uart_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid),
    .enable (gap_enable),
    .expired(gap_expired)
  );

  // Framing FSM; block_data doubles as the shift buffer so it is stable in hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ASM_IDLE;
      block_data  <= '0;
      block_valid <= 1'b0;
      byte_count  <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      case (state)
        ASM_IDLE: begin
          if (rx_valid) begin
            block_data <= {{(BLOCK_BITS-8){1'b0}}, rx_data};
            byte_count <= 5'd1;
            state      <= ASM_COLLECT;
          end
        end
        ASM_COLLECT: begin
          if (rx_valid) begin
            block_data <= {block_data[BLOCK_BITS-9:0], rx_data};
            byte_count <= byte_count + 5'd1;
            if (byte_count == LAST_COUNT) begin
              block_valid <= 1'b1;
              state       <= ASM_HOLD;
            end
          end else if (gap_expired) begin
            block_data  <= '0;
            byte_count  <= '0;
            timeout_err <= 1'b1;
            state       <= ASM_IDLE;
          end
        end
        ASM_HOLD: begin
          if (block_ready) begin
            block_valid <= 1'b0;
            if (rx_valid) begin
              // Byte arriving on the accept cycle opens the next block.
              block_data <= {{(BLOCK_BITS-8){1'b0}}, rx_data};
              byte_count <= 5'd1;
              state      <= ASM_COLLECT;
            end else begin
              byte_count <= '0;
              state      <= ASM_IDLE;
            end
          end else if (rx_valid) begin
            overrun_err <= 1'b1;
          end
        end
        default: begin
          state <= ASM_IDLE;
        end
      endcase
    end
  end

endmodule : uart_block_assembler

// File: tb/tb_uart_block_assembler.sv
// Directed bench for uart_block_assembler with a block scoreboard.
module tb_uart_block_assembler;

  localparam int unsigned CLK_FREQ  = 1_000_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int unsigned GAP_BYTES = 2;
  localparam int unsigned BYTE_T    = (CLK_FREQ / BAUD_RATE) * 10;
  localparam int unsigned GAP       = BYTE_T * GAP_BYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] block_data;
  logic         block_valid;
  logic         block_ready;
  logic         timeout_err;
  logic         overrun_err;
  logic [4:0]   byte_count;

  logic [127:0] exp_q[$];
  int n_checks  = 0;
  int n_passed  = 0;
  int n_failed  = 0;
  int n_accept  = 0;
  int n_timeout = 0;
  int n_overrun = 0;

  uart_block_assembler #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .GAP_BYTES(GAP_BYTES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .block_data (block_data),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8]);
  endtask

  // Scoreboard and error-pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (timeout_err) n_timeout++;
      if (overrun_err) n_overrun++;
      if (block_valid && block_ready) begin
        n_accept++;
        if (exp_q.size() == 0) check("scoreboard_empty", 128'(exp_q.size()), 128'd1);
        else check("block_data_accept", block_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [127:0] blk;
    int bad;

    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; block_ready = 1'b0;
    idle(3);
    check("rst_block_data", block_data, '0);
    check("rst_block_valid", 128'(block_valid), 128'd0);
    check("rst_byte_count", 128'(byte_count), 128'd0);
    check("rst_timeout_err", 128'(timeout_err), 128'd0);
    check("rst_overrun_err", 128'(overrun_err), 128'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back frame with consumer always ready
    block_ready = 1'b1;
    blk = 128'h000102030405060708090A0B0C0D0E0F;
    exp_q.push_back(blk);
    send_block(blk);
    check("b2b_valid", 128'(block_valid), 128'd1);
    check("b2b_count", 128'(byte_count), 128'd16);
    check("b2b_data", block_data, blk);
    step();
    check("b2b_valid_fall", 128'(block_valid), 128'd0);
    check("b2b_count_zero", 128'(byte_count), 128'd0);
    check("b2b_accepts", 128'(n_accept), 128'd1);

    // Baud-spaced frame held for 50 cycles before acceptance
    block_ready = 1'b0;
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) begin
      send_byte(blk[127-8*i -: 8]);
      if (i != 15) idle(BYTE_T - 1);
    end
    check("spaced_valid", 128'(block_valid), 128'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (block_data !== blk || block_valid !== 1'b1) bad++;
      step();
    end
    check("hold_stable_cycles", 128'(bad), 128'd0);
    exp_q.push_back(blk);
    block_ready = 1'b1;
    step();
    check("spaced_valid_fall", 128'(block_valid), 128'd0);
    check("spaced_count_zero", 128'(byte_count), 128'd0);
    check("spaced_accepts", 128'(n_accept), 128'd2);
    check("no_err_so_far", 128'(n_timeout + n_overrun), 128'd0);

    // Partial block abandoned by gap timeout
    for (int i = 0; i < 5; i++) send_byte(8'hAA);
    idle(GAP - 1);
    check("pre_timeout_err", 128'(timeout_err), 128'd0);
    check("pre_timeout_count", 128'(byte_count), 128'd5);
    step();
    check("timeout_pulse", 128'(timeout_err), 128'd1);
    check("timeout_count", 128'(byte_count), 128'd0);
    step();
    check("timeout_pulse_end", 128'(timeout_err), 128'd0);
    blk = {16{8'h11}};
    exp_q.push_back(blk);
    send_block(blk);
    check("after_timeout_data", block_data, blk);
    step();
    check("timeout_count_total", 128'(n_timeout), 128'd1);

    // Byte landing exactly on the terminal-count cycle keeps the block alive
    blk = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    exp_q.push_back(blk);
    for (int i = 0; i < 5; i++) send_byte(blk[127-8*i -: 8]);
    idle(GAP - 1);
    send_byte(blk[127-40 -: 8]);
    check("term_no_timeout", 128'(timeout_err), 128'd0);
    check("term_count", 128'(byte_count), 128'd6);
    for (int i = 6; i < 16; i++) send_byte(blk[127-8*i -: 8]);
    check("term_valid", 128'(block_valid), 128'd1);
    step();
    check("term_timeout_total", 128'(n_timeout), 128'd1);

    // Overrun while holding, then a byte on the accept cycle
    block_ready = 1'b0;
    blk = 128'h202122232425262728292A2B2C2D2E2F;
    send_block(blk);
    check("ovr_valid", 128'(block_valid), 128'd1);
    send_byte(8'h55);
    check("ovr_pulse", 128'(overrun_err), 128'd1);
    check("ovr_data_kept", block_data, blk);
    check("ovr_count", 128'(byte_count), 128'd16);
    step();
    check("ovr_pulse_end", 128'(overrun_err), 128'd0);
    check("ovr_still_valid", 128'(block_valid), 128'd1);
    exp_q.push_back(blk);
    blk = 128'h778899AABBCCDDEEFF0123456789ABCD;
    exp_q.push_back(blk);
    block_ready = 1'b1;
    send_byte(8'h77);
    check("accept_byte_valid", 128'(block_valid), 128'd0);
    check("accept_byte_count", 128'(byte_count), 128'd1);
    for (int i = 1; i < 16; i++) send_byte(blk[127-8*i -: 8]);
    check("next_block_data", block_data, blk);
    step();
    block_ready = 1'b0;
    check("overrun_total", 128'(n_overrun), 128'd1);

    // Asynchronous reset mid-block
    for (int i = 0; i < 9; i++) send_byte(8'h90 + 8'(i));
    check("mid_count", 128'(byte_count), 128'd9);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", block_data, '0);
    check("async_rst_count", 128'(byte_count), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    block_ready = 1'b1;
    blk = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    exp_q.push_back(blk);
    send_block(blk);
    check("post_rst_data", block_data, blk);
    step();

    // Asynchronous reset while holding
    block_ready = 1'b0;
    send_block(128'h0F0E0D0C0B0A09080706050403020100);
    check("hold_pre_rst_valid", 128'(block_valid), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("hold_rst_valid", 128'(block_valid), 128'd0);
    check("hold_rst_data", block_data, '0);
    check("hold_rst_count", 128'(byte_count), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    block_ready = 1'b1;
    blk = 128'h5A5A5A5AA5A5A5A50123456789ABCDEF;
    exp_q.push_back(blk);
    send_block(blk);
    step();
    step();

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    check("accept_total", 128'(n_accept), 128'd8);
    check("timeout_total", 128'(n_timeout), 128'd1);
    check("overrun_total_end", 128'(n_overrun), 128'd1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule : tb_uart_block_assembler
